// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the multi-lane HDMI TMDS encoder.
// Symbol constants are written as o_tmds[9:0]; bit 0 leaves the serialiser first.
package tmds_pkg;

    localparam logic [1:0] MODE_CTRL  = 2'b00;
    localparam logic [1:0] MODE_VIDEO = 2'b01;
    localparam logic [1:0] MODE_TERC4 = 2'b10;
    localparam logic [1:0] MODE_GB    = 2'b11;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] GB_VID_02 = 10'b1011001100;
    localparam logic [9:0] GB_VID_1  = 10'b0100110011;

    function automatic logic [9:0] ctrl_encode(input logic [1:0] c);
        logic [9:0] s;
        unique case (c)
            2'b00: s = CTRL_00;
            2'b01: s = CTRL_01;
            2'b10: s = CTRL_10;
            2'b11: s = CTRL_11;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_encode(input logic [3:0] nib);
        logic [9:0] s;
        unique case (nib)
            4'h0: s = 10'b1010011100;
            4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;
            4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;
            4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;
            4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;
            4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;
            4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;
            4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;
            4'hF: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 builds q_m, stage 2 picks the symbol and
// tracks running disparity. LANE_IDX selects the guard-band code.
module tmds_lane
    import tmds_pkg::*;
#(
    parameter int LANE_IDX = 0,
    parameter int DISP_W   = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_ce,
    input  logic [1:0]               i_mode,
    input  logic                     i_gb_island,
    input  logic [7:0]               i_pixel,
    input  logic [1:0]               i_ctrl,
    input  logic [3:0]               i_terc4,
    output logic [9:0]               o_tmds,
    output logic signed [DISP_W-1:0] o_disparity
);

    localparam logic signed [DISP_W-1:0] TWO = DISP_W'(2);

    logic [8:0] qm_d;
    logic [3:0] n1_pix;
    logic       use_xnor;

    logic [8:0] s1_qm;
    logic [1:0] s1_mode;
    logic [1:0] s1_ctrl;
    logic [3:0] s1_terc4;
    logic       s1_gb;

    logic [3:0]               ones;
    logic                     q8;
    logic signed [DISP_W-1:0] bal;
    logic                     cnt_pos, cnt_neg, bal_pos, bal_neg;
    logic [9:0]               sym_nxt;
    logic signed [DISP_W-1:0] cnt_nxt;

    always_comb begin
        n1_pix   = popcount8(i_pixel);
        use_xnor = (n1_pix > 4'd4) || (n1_pix == 4'd4 && !i_pixel[0]);
        qm_d     = '0;
        qm_d[0]  = i_pixel[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ i_pixel[i])
                               :  (qm_d[i-1] ^ i_pixel[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_qm    <= '0;
            s1_mode  <= MODE_CTRL;
            s1_ctrl  <= 2'b00;
            s1_terc4 <= '0;
            s1_gb    <= 1'b0;
        end else if (i_ce) begin
            s1_qm    <= qm_d;
            s1_mode  <= i_mode;
            s1_ctrl  <= i_ctrl;
            s1_terc4 <= i_terc4;
            s1_gb    <= i_gb_island;
        end
    end

    // bal = n1 - n0 of q_m[7:0], always even in -8..8
    always_comb begin
        ones    = popcount8(s1_qm[7:0]);
        q8      = s1_qm[8];
        bal     = DISP_W'(ones) + DISP_W'(ones) - DISP_W'(8);
        cnt_neg = o_disparity[DISP_W-1];
        cnt_pos = !cnt_neg && (o_disparity != '0);
        bal_neg = bal[DISP_W-1];
        bal_pos = !bal_neg && (bal != '0);
        sym_nxt = CTRL_00;
        cnt_nxt = '0;
        unique case (s1_mode)
            MODE_VIDEO: begin
                unique case (1'b1)
                    (o_disparity == '0) || (bal == '0): begin
                        sym_nxt = {~q8, q8, q8 ? s1_qm[7:0] : ~s1_qm[7:0]};
                        cnt_nxt = q8 ? o_disparity + bal : o_disparity - bal;
                    end
                    (cnt_pos && bal_pos) || (cnt_neg && bal_neg): begin
                        sym_nxt = {1'b1, q8, ~s1_qm[7:0]};
                        cnt_nxt = o_disparity + (q8 ? TWO : '0) - bal;
                    end
                    default: begin
                        sym_nxt = {1'b0, q8, s1_qm[7:0]};
                        cnt_nxt = o_disparity - (q8 ? '0 : TWO) + bal;
                    end
                endcase
            end
            MODE_CTRL:  sym_nxt = ctrl_encode(s1_ctrl);
            MODE_TERC4: sym_nxt = terc4_encode(s1_terc4);
            MODE_GB: begin
                if (s1_gb)
                    sym_nxt = (LANE_IDX == 0) ? terc4_encode(s1_terc4) : GB_VID_1;
                else
                    sym_nxt = (LANE_IDX % 2 == 0) ? GB_VID_02 : GB_VID_1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tmds      <= CTRL_00;
            o_disparity <= '0;
        end else if (i_ce) begin
            o_tmds      <= sym_nxt;
            o_disparity <= cnt_nxt;
        end
    end

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-lane HDMI TMDS encoder: NUM_CH lanes in lockstep plus a
// mode pipeline matching the two-stage lane latency.
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_ce,
    input  logic [1:0]                 i_mode,
    input  logic                       i_gb_island,
    input  logic [8*NUM_CH-1:0]        i_pixel,
    input  logic [2*NUM_CH-1:0]        i_ctrl,
    input  logic [4*NUM_CH-1:0]        i_terc4,
    output logic [10*NUM_CH-1:0]       o_tmds,
    output logic [1:0]                 o_mode,
    output logic [DISP_W*NUM_CH-1:0]   o_disparity
);

    logic [1:0] mode_s1;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        tmds_lane #(
            .LANE_IDX (n),
            .DISP_W   (DISP_W)
        ) u_lane (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_ce        (i_ce),
            .i_mode      (i_mode),
            .i_gb_island (i_gb_island),
            .i_pixel     (i_pixel[8*n +: 8]),
            .i_ctrl      (i_ctrl[2*n +: 2]),
            .i_terc4     (i_terc4[4*n +: 4]),
            .o_tmds      (o_tmds[10*n +: 10]),
            .o_disparity (o_disparity[DISP_W*n +: DISP_W])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_s1 <= MODE_CTRL;
            o_mode  <= MODE_CTRL;
        end else if (i_ce) begin
            mode_s1 <= i_mode;
            o_mode  <= mode_s1;
        end
    end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Scoreboard bench for tmds_encoder_mc with four lanes: an independent
// reference encoder queues expected symbols at drive time.
module tb_tmds_encoder_mc;

    localparam int NC = 4;
    localparam int DW = 5;

    localparam logic [9:0] T4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    localparam logic [9:0] CC [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ce = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic              gb = 1'b0;
    logic [8*NC-1:0]   pix = '0;
    logic [2*NC-1:0]   ctl = '0;
    logic [4*NC-1:0]   t4 = '0;
    logic [10*NC-1:0]  tmds;
    logic [1:0]        omode;
    logic [DW*NC-1:0]  disp;

    tmds_encoder_mc #(.NUM_CH(NC), .DISP_W(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ce        (ce),
        .i_mode      (mode),
        .i_gb_island (gb),
        .i_pixel     (pix),
        .i_ctrl      (ctl),
        .i_terc4     (t4),
        .o_tmds      (tmds),
        .o_mode      (omode),
        .o_disparity (disp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10*NC-1:0] sym;
        logic [1:0]       md;
        logic [DW*NC-1:0] dsp;
        bit               dir;
        logic [10*NC-1:0] dsym;
        logic [10*NC-1:0] dmask;
        logic [DW-1:0]    ddisp;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cnt_m [NC];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_sym(input int lane, input logic [1:0] m,
                           input logic g, input logic [7:0] d,
                           input logic [1:0] c, input logic [3:0] t,
                           inout int cnt, output logic [9:0] s);
        int n1, ones, zeros;
        logic [8:0] qm;
        s = 10'b0;
        if (m != 2'b01) begin
            cnt = 0;
            case (m)
                2'b00: s = CC[c];
                2'b10: s = T4[t];
                default: begin
                    if (g) s = (lane == 0) ? T4[t] : 10'b0100110011;
                    else   s = (lane == 0 || lane == 2) ? 10'b1011001100
                                                        : 10'b0100110011;
                end
            endcase
        end else begin
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(d[i]);
            qm[0] = d[0];
            if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
                for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
                qm[8] = 1'b0;
            end else begin
                for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
                qm[8] = 1'b1;
            end
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(qm[i]);
            zeros = 8 - ones;
            if (cnt == 0 || ones == zeros) begin
                s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                cnt += qm[8] ? (ones - zeros) : (zeros - ones);
            end else if ((cnt > 0 && ones > zeros) || (cnt < 0 && zeros > ones)) begin
                s = {1'b1, qm[8], ~qm[7:0]};
                cnt += 2 * int'(qm[8]) + zeros - ones;
            end else begin
                s = {1'b0, qm[8], qm[7:0]};
                cnt += -2 * int'(!qm[8]) + ones - zeros;
            end
        end
    endtask

    task automatic seed();
        exp_t e;
        q.delete();
        for (int l = 0; l < NC; l++) cnt_m[l] = 0;
        e.sym = {NC{CC[0]}};
        e.md = 2'b00;
        e.dsp = '0;
        e.dir = 1'b0;
        e.dsym = '0;
        e.dmask = '0;
        e.ddisp = '0;
        q.push_back(e);
        cur = e;
    endtask

    task automatic step(input logic c_e, input logic [1:0] m, input logic g,
                        input logic [8*NC-1:0] p, input logic [2*NC-1:0] c,
                        input logic [4*NC-1:0] t, input bit dir,
                        input logic [10*NC-1:0] dsym,
                        input logic [10*NC-1:0] dmask,
                        input logic [DW-1:0] ddisp);
        exp_t e;
        logic [9:0] s;
        ce = c_e; mode = m; gb = g; pix = p; ctl = c; t4 = t;
        if (c_e) begin
            e.md = m; e.dir = dir; e.dsym = dsym;
            e.dmask = dmask; e.ddisp = ddisp;
            for (int l = 0; l < NC; l++) begin
                ref_sym(l, m, g, p[8*l +: 8], c[2*l +: 2], t[4*l +: 4], cnt_m[l], s);
                e.sym[10*l +: 10] = s;
                e.dsp[DW*l +: DW] = cnt_m[l][DW-1:0];
            end
            q.push_back(e);
        end
        @(posedge clk); #1;
        if (c_e) begin
            if (q.size() == 0) chk("queue_empty", 64'd1, 64'd0);
            else cur = q.pop_front();
        end
        chk("tmds", tmds, cur.sym);
        chk("mode", omode, cur.md);
        chk("disp", disp, cur.dsp);
        if (c_e && cur.dir) begin
            chk("dir_sym", tmds & cur.dmask, cur.dsym & cur.dmask);
            chk("dir_disp", disp[DW-1:0], cur.ddisp);
        end
    endtask

    task automatic rnd(input logic c_e, input logic [1:0] m, input logic g);
        step(c_e, m, g, {$urandom(), $urandom()}, 8'($urandom()),
             16'($urandom()), 0, '0, '0, '0);
    endtask

    task automatic lane0(input logic [1:0] m, input logic g,
                         input logic [7:0] p0, input logic [1:0] c0,
                         input logic [3:0] t0, input logic [10*NC-1:0] dsym,
                         input logic [10*NC-1:0] dmask, input logic [DW-1:0] dd);
        logic [8*NC-1:0] p;
        logic [2*NC-1:0] c;
        logic [4*NC-1:0] t;
        p = {$urandom(), $urandom()}; p[7:0] = p0;
        c = 8'($urandom()); c[1:0] = c0;
        t = 16'($urandom()); t[3:0] = t0;
        step(1'b1, m, g, p, c, t, 1, dsym, dmask, dd);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tmds"}, tmds, {NC{10'b1101010100}});
        chk({tag, "_mode"}, omode, 2'b00);
        chk({tag, "_disp"}, disp, '0);
    endtask

    task automatic drop_range();
        int d;
        for (int l = 0; l < NC; l++) begin
            d = int'($signed(disp[DW*l +: DW]));
            chk("disp_range", 64'(d >= -10 && d <= 10), 64'd1);
        end
    endtask

    localparam logic [10*NC-1:0] M0 = 40'h00000003FF;
    localparam logic [10*NC-1:0] MALL = {40{1'b1}};

    initial begin
        int npix;
        // reset held with live random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1; mode = 2'($urandom()); gb = 1'($urandom());
            pix = {$urandom(), $urandom()}; ctl = 8'($urandom()); t4 = 16'($urandom());
            @(posedge clk); #1;
            chk_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
        seed();
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0, '0, '0, '0, 0, '0, '0, '0);

        // control, then three zero pixels on lane 0
        lane0(2'b00, 1'b0, 8'h00, 2'b01, 4'h0, 40'h000000_00AB, M0, 5'd0);
        lane0(2'b01, 1'b0, 8'h00, 2'b00, 4'h0, 40'h100, M0, 5'b11000);
        lane0(2'b01, 1'b0, 8'h00, 2'b00, 4'h0, 40'h3FF, M0, 5'b00010);
        lane0(2'b01, 1'b0, 8'h00, 2'b00, 4'h0, 40'h100, M0, 5'b11010);
        // TERC4 extremes
        lane0(2'b10, 1'b0, 8'h00, 2'b00, 4'h0, {30'b0, 10'b1010011100}, M0, 5'd0);
        lane0(2'b10, 1'b0, 8'h00, 2'b00, 4'hF, {30'b0, 10'b1011000011}, M0, 5'd0);
        // guard bands
        lane0(2'b11, 1'b0, 8'h00, 2'b00, 4'h0,
              {10'b0100110011, 10'b1011001100, 10'b0100110011, 10'b1011001100},
              MALL, 5'd0);
        lane0(2'b11, 1'b1, 8'h00, 2'b00, 4'hC,
              {10'b0100110011, 10'b0100110011, 10'b0100110011, 10'b1010001110},
              MALL, 5'd0);
        for (int i = 0; i < 3; i++) rnd(1'b1, 2'b00, 1'b0);

        // clock-enable hold mid-video
        for (int i = 0; i < 6; i++) rnd(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) rnd(1'b0, 2'($urandom()), 1'($urandom()));
        for (int i = 0; i < 6; i++) rnd(1'b1, 2'b01, 1'b0);

        // async reset mid-line
        for (int i = 0; i < 4; i++) rnd(1'b1, 2'b01, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_async");
        @(posedge clk); #1;
        chk_reset_outputs("rst_async_hold");
        rst_n = 1'b1;
        seed();
        for (int i = 0; i < 4; i++) rnd(1'b1, 2'b01, 1'b0);

        // random video bursts with blanking in between
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 4; i++) rnd(1'b1, 2'b00, 1'b0);
            npix = 0;
            while (npix < 500) begin
                ce = ($urandom_range(0, 9) != 0);
                if (ce) npix++;
                rnd(ce, 2'b01, 1'b0);
            end
            drop_range();
        end

        // back-to-back random mode switches
        for (int i = 0; i < 600; i++)
            rnd(1'($urandom_range(0, 7) != 0), 2'($urandom()), 1'($urandom()));
        drop_range();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_mc.md
Name: tmds_encoder_mc

Overview:
Parametrised multi-channel HDMI TMDS encoder. It is the successor to the single-channel DVI encoder.
- Encodes NUM_CH lanes in lockstep, one 10-bit symbol per lane per pixel clock.
- Adds the HDMI period types the DVI encoder lacks: TERC4 data-island symbols and video/data-island guard bands.
- Adds a clock enable and a per-lane running-disparity readout.
- Sits between the video timing/packet scheduler and the 10:1 serialisers.

Parameters:
NUM_CH, 3, number of TMDS lanes (1..4); lane 0 = blue/sync lane.
DISP_W, 5, width of the signed running-disparity counter (min 5).

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_ce  in  1  clock enable; 0 = every register holds
i_mode  in  2  period type: 00 control, 01 video, 10 data island (TERC4), 11 guard band
i_gb_island  in  1  guard-band flavour when i_mode=11: 0 video GB, 1 data-island GB
i_pixel  in  8*NUM_CH  video bytes, lane n at [8n+7:8n]
i_ctrl  in  2*NUM_CH  control bits {C1,C0}, lane n at [2n+1:2n]
i_terc4  in  4*NUM_CH  TERC4 nibbles, lane n at [4n+3:4n]
o_tmds  out  10*NUM_CH  encoded symbols, lane n at [10n+9:10n], bit 0 sent first
o_mode  out  2  i_mode delayed to align with o_tmds
o_disparity  out  DISP_W*NUM_CH  per-lane signed running disparity after the symbol now on o_tmds

Behaviour:
- Latency: fixed 2 enabled cycles from inputs to o_tmds/o_mode.
  - Stage 1 registers q_m[8:0], mode, ctrl, terc4 and gb_island per lane.
  - Stage 2 registers o_tmds and updates disparity.
- i_ce=0: nothing advances; outputs and disparity are stable.
- Reset (async assert, sync release):
  - every lane o_tmds = 10'b1101010100 (control 00);
  - o_mode = 00;
  - all disparity counters = 0;
  - stage-1 registers cleared to mode 00, ctrl 00.
- Stage 1 (video):
  - N1 = popcount(pixel).
  - XNOR chain if N1>4 or (N1==4 and pixel[0]==0), with q_m[8]=0.
  - Otherwise XOR chain, with q_m[8]=1.
  - q_m[0] = pixel[0] in both cases.
- Stage 2 (video), per lane; n1/n0 = ones/zeros of q_m[7:0]; cnt = disparity:
  - If cnt==0 or n1==n0:
    - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]};
    - cnt += q_m8 ? (n1-n0) : (n0-n1).
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out = {1, q_m8, ~q_m[7:0]};
    - cnt += 2*q_m8 + (n0-n1).
  - Else:
    - out = {0, q_m8, q_m[7:0]};
    - cnt += -2*(~q_m8) + (n1-n0).
  - Arithmetic is signed DISP_W-bit; the counter never exceeds ±10, so no saturation is needed.
- Control mode, code by {C1,C0}:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- TERC4 mode: each lane's nibble maps through the HDMI 1.4 TERC4 table (0000→1010011100 … 1111→1011000011).
- Guard band, video (i_gb_island=0):
  - lanes 0 and 2 → 1011001100;
  - lane 1 → 0100110011;
  - lane 3 → 0100110011.
- Guard band, data island (i_gb_island=1):
  - lane 0 → TERC4(i_terc4[3:0]); the scheduler supplies {1,1,VSYNC,HSYNC};
  - lanes ≥1 → 0100110011.
- Disparity counter: any enabled non-video stage-2 cycle forces cnt=0 for all lanes. Video after any other mode therefore starts from 0.
- Mode changes take effect on any cycle boundary; there is no settling or illegal transition. Back-to-back mode switches each produce the correctly coded symbol 2 cycles later.
- Reset asserted mid-line: outputs go to reset values immediately. The first enabled cycle after release re-fills the pipeline. o_tmds carries the reset code until 2 enabled cycles have passed.

Decomposition:
- Package tmds_pkg holds:
  - mode constants (MODE_CTRL, MODE_VIDEO, MODE_TERC4, MODE_GB);
  - the 4 control codes;
  - guard-band codes GB_VID_02, GB_VID_1;
  - function terc4_encode(nibble) implemented as a 16-entry case ROM;
  - function popcount8.
- One sub-module, tmds_lane: a 2-stage single-lane encoder with disparity and a LANE_IDX parameter selecting guard-band codes. The top generates NUM_CH instances and aligns o_mode.

Test Plan:
- Reset: hold i_rst_n=0 with i_ce=1 and random inputs → every lane 10'b1101010100, o_mode=00, disparity 0. Release → same for 2 cycles.
- Video disparity: control, then pixel 0x00 ×3 on lane 0 → o_tmds 0100000000, 1111111111, 0100000000; disparity -8, +2, -6.
- Control/TERC4: ctrl 01 → 0010101011. TERC4 nibble 0000 → 1010011100, nibble 1111 → 1011000011. Disparity reads 0 on each.
- Guard bands: video GB → lanes 0,1,2 = 1011001100, 0100110011, 1011001100. Data-island GB with i_terc4[3:0]=1100 → lane 0 = 1010001110.
- Clock enable: drop i_ce for 5 cycles mid-video → o_tmds/o_disparity frozen. On resume the sequence is identical to an uninterrupted run.
- Random video bursts (10k pixels, NUM_CH=4) against a reference model → bit-exact match. Disparity stays within ±10 and returns to 0 after each blanking.
